uart_tx_fifo: RTL and testbench

//  Transmit FIFO directly upstream of the UART transmit controller. Buffers bytes written by
//  the register/bus side and presents the head entry as TxDataReady/TxData. Detects that the

---
 rtl/uart_tx_fifo.sv | 106 ++++++++++
 tb/tb_uart_tx_fifo.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO feeding the UART Tx controller; pops the head entry when the controller loads it.
// Optional level interrupt (IrqLevel/TxIrq) is built when UART_TX_FIFO_IRQ_EN is defined.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  CLK,
    input  logic                  RESETn,
    input  logic                  WrEn,
    input  logic [7:0]            WrData,
    input  logic                  Flush,
    input  logic                  OvfClr,
    input  logic                  TxBusy,
    input  logic                  TxDone,
    output logic                  TxDataReady,
    output logic [7:0]            TxData,
    output logic                  Full,
    output logic                  Empty,
    output logic [DEPTH_LOG2:0]   Count,
`ifdef UART_TX_FIFO_IRQ_EN
    input  logic [DEPTH_LOG2:0]   IrqLevel,
    output logic                  TxIrq,
`endif
    output logic                  Overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = DEPTH[DEPTH_LOG2:0];

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtr;
    logic [DEPTH_LOG2-1:0] rdPtr;
    logic [DEPTH_LOG2:0]   countReg;
    logic [DEPTH_LOG2:0]   countNext;
    logic                  txBusyD;
    logic                  txDoneD;
    logic                  overflowReg;
    logic                  load;
    logic                  wrAccept;
    logic                  popAccept;

    assign Count       = countReg;
    assign Empty       = (countReg == '0);
    assign Full        = (countReg == DEPTH_CNT);
    assign TxDataReady = !Empty;
    assign TxData      = mem[rdPtr];
    assign Overflow    = overflowReg;

    // A rising TxBusy is IDLE->START; a falling TxDone while still busy is STOP->START.
    assign load      = (TxBusy & ~txBusyD) | (txDoneD & ~TxDone & TxBusy);
    assign wrAccept  = WrEn & ~Full & ~Flush;
    assign popAccept = load & ~Empty & ~Flush;

    always_comb begin
        countNext = countReg;
        if (Flush) begin
            countNext = '0;
        end else begin
            case ({wrAccept, popAccept})
                2'b10:   countNext = countReg + 1'b1;
                2'b01:   countNext = countReg - 1'b1;
                default: countNext = countReg;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            countReg    <= '0;
            txBusyD     <= 1'b0;
            txDoneD     <= 1'b0;
            overflowReg <= 1'b0;
        end else begin
            txBusyD  <= TxBusy;
            txDoneD  <= TxDone;
            countReg <= countNext;
            if (Flush) begin
                rdPtr <= wrPtr;
            end else begin
                if (wrAccept)  wrPtr <= wrPtr + 1'b1;
                if (popAccept) rdPtr <= rdPtr + 1'b1;
            end
            // Full is judged before any same-cycle pop, and a new overflow beats a clear.
            if (WrEn && Full)
                overflowReg <= 1'b1;
            else if (OvfClr)
                overflowReg <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (wrAccept)
            mem[wrPtr] <= WrData;
    end

`ifdef UART_TX_FIFO_IRQ_EN
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn)
            TxIrq <= 1'b0;
        else
            TxIrq <= (countNext <= IrqLevel);
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized self-checking bench for uart_tx_fifo against a queue-based reference model.
// Build with +define+UART_TX_FIFO_IRQ_EN to also exercise the level interrupt.
module tb_uart_tx_fifo;

    localparam int DL    = 4;
    localparam int DEPTH = 1 << DL;

    logic          CLK = 1'b0;
    logic          RESETn = 1'b0;
    logic          WrEn = 1'b0;
    logic [7:0]    WrData = '0;
    logic          Flush = 1'b0;
    logic          OvfClr = 1'b0;
    logic          TxBusy = 1'b0;
    logic          TxDone = 1'b0;
    logic          TxDataReady;
    logic [7:0]    TxData;
    logic          Full;
    logic          Empty;
    logic [DL:0]   Count;
    logic          Overflow;
`ifdef UART_TX_FIFO_IRQ_EN
    logic [DL:0]   IrqLevel = '0;
    logic          TxIrq;
`endif

    uart_tx_fifo #(.DEPTH_LOG2(DL)) dut (
        .CLK(CLK), .RESETn(RESETn), .WrEn(WrEn), .WrData(WrData), .Flush(Flush),
        .OvfClr(OvfClr), .TxBusy(TxBusy), .TxDone(TxDone), .TxDataReady(TxDataReady),
        .TxData(TxData), .Full(Full), .Empty(Empty), .Count(Count),
`ifdef UART_TX_FIFO_IRQ_EN
        .IrqLevel(IrqLevel), .TxIrq(TxIrq),
`endif
        .Overflow(Overflow)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: byte queue plus the controller handshake history.
    byte unsigned modelQ[$];
    bit modelBusyD, modelDoneD, modelOvf, modelIrq;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        modelQ.delete();
        modelBusyD = 1'b0;
        modelDoneD = 1'b0;
        modelOvf   = 1'b0;
        modelIrq   = 1'b0;
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".count"}, 32'(Count), 32'(modelQ.size()));
        checkOutput({tag, ".empty"}, 32'(Empty), 32'(modelQ.size() == 0));
        checkOutput({tag, ".full"}, 32'(Full), 32'(modelQ.size() == DEPTH));
        checkOutput({tag, ".ready"}, 32'(TxDataReady), 32'(modelQ.size() != 0));
        checkOutput({tag, ".ovf"}, 32'(Overflow), 32'(modelOvf));
        if (modelQ.size() != 0)
            checkOutput({tag, ".data"}, 32'(TxData), 32'(modelQ[0]));
`ifdef UART_TX_FIFO_IRQ_EN
        checkOutput({tag, ".irq"}, 32'(TxIrq), 32'(modelIrq));
`endif
    endtask

    // Drive one cycle of inputs, advance the model by the rules, then check after the edge.
    task automatic applyStimulus(input string tag, input bit wr, input logic [7:0] data,
                                 input bit fl, input bit oc, input bit busy, input bit done);
        bit wasFull, isLoad;
        @(negedge CLK);
        WrEn = wr; WrData = data; Flush = fl; OvfClr = oc; TxBusy = busy; TxDone = done;
        wasFull = (modelQ.size() == DEPTH);
        isLoad  = (busy && !modelBusyD) || (modelDoneD && !done && busy);
        if (fl) begin
            modelQ.delete();
        end else begin
            if (isLoad && modelQ.size() != 0) void'(modelQ.pop_front());
            if (wr && !wasFull) modelQ.push_back(data);
        end
        if (wr && wasFull) modelOvf = 1'b1;
        else if (oc)       modelOvf = 1'b0;
        modelBusyD = busy;
        modelDoneD = done;
`ifdef UART_TX_FIFO_IRQ_EN
        modelIrq = (modelQ.size() <= int'(IrqLevel));
`endif
        @(posedge CLK);
        #1;
        checkAll(tag);
    endtask

    task automatic doReset();
        @(negedge CLK);
        WrEn = 0; Flush = 0; OvfClr = 0; TxBusy = 0; TxDone = 0;
        RESETn = 1'b0;
        modelReset();
        #2;
        checkAll("reset");
        @(negedge CLK);
        RESETn = 1'b1;
    endtask

    initial begin
        modelReset();
        #12;
        checkAll("reset0");
        RESETn = 1'b1;

        // Single write becomes visible as head on the next cycle.
        applyStimulus("t1", 1, 8'h55, 0, 0, 0, 0);
        checkOutput("t1.const", 32'(TxData), 32'h55);

        // Fill, overflow, clear, drain in order.
        doReset();
        for (int i = 0; i < DEPTH; i++) applyStimulus("t2fill", 1, 8'(i), 0, 0, 0, 0);
        checkOutput("t2.full", 32'(Full), 32'd1);
        applyStimulus("t2ovf", 1, 8'hAA, 0, 0, 0, 0);
        checkOutput("t2.ovfconst", 32'(Overflow), 32'd1);
        applyStimulus("t2clr", 0, 8'h00, 0, 1, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput("t2.order", 32'(TxData), 32'(i));
            applyStimulus("t2pop", 0, 8'h00, 0, 0, 1, 0);
            applyStimulus("t2idle", 0, 8'h00, 0, 0, 0, 0);
        end
        checkOutput("t2.empty", 32'(Empty), 32'd1);

        // Load detection: IDLE->START then STOP->START.
        doReset();
        applyStimulus("t3w", 1, 8'h11, 0, 0, 0, 0);
        applyStimulus("t3w", 1, 8'h22, 0, 0, 0, 0);
        applyStimulus("t3start", 0, 8'h00, 0, 0, 1, 0);
        checkOutput("t3.data", 32'(TxData), 32'h22);
        applyStimulus("t3stop", 0, 8'h00, 0, 0, 1, 1);
        applyStimulus("t3b2b", 0, 8'h00, 0, 0, 1, 0);
        checkOutput("t3.empty", 32'(Empty), 32'd1);

        // STOP->IDLE and busy drop must not pop.
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus("t4w", 1, 8'(8'h30 + i), 0, 0, 0, 0);
        applyStimulus("t4start", 0, 8'h00, 0, 0, 1, 0);
        applyStimulus("t4stop", 0, 8'h00, 0, 0, 1, 1);
        applyStimulus("t4idle", 0, 8'h00, 0, 0, 0, 0);
        applyStimulus("t4hold", 0, 8'h00, 0, 0, 0, 0);
        checkOutput("t4.count", 32'(Count), 32'd3);
        checkOutput("t4.data", 32'(TxData), 32'h31);

        // Concurrent write/pop, flush priority, pointer wrap.
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus("t5w", 1, 8'(8'h40 + i), 0, 0, 0, 0);
        applyStimulus("t5wp", 1, 8'h45, 0, 0, 1, 0);
        checkOutput("t5.count", 32'(Count), 32'd5);
        applyStimulus("t5flush", 1, 8'h99, 1, 0, 0, 0);
        checkOutput("t5.flush", 32'(Empty), 32'd1);
        for (int i = 0; i < 40; i++) begin
            applyStimulus("t5wrapA", 1, 8'(i * 7), 0, 0, 1, 0);
            applyStimulus("t5wrapB", 1, 8'(i * 7 + 3), 0, 0, 0, 0);
        end

`ifdef UART_TX_FIFO_IRQ_EN
        doReset();
        IrqLevel = 5'd2;
        for (int i = 0; i < 3; i++) applyStimulus("t6w", 1, 8'(i), 0, 0, 0, 0);
        checkOutput("t6.irqlow", 32'(TxIrq), 32'd0);
        applyStimulus("t6pop", 0, 8'h00, 0, 0, 1, 0);
        checkOutput("t6.irqhigh", 32'(TxIrq), 32'd1);
        applyStimulus("t6w3", 1, 8'h03, 0, 0, 1, 0);
        applyStimulus("t6w4", 1, 8'h04, 0, 0, 0, 0);
        checkOutput("t6.irqoff", 32'(TxIrq), 32'd0);
`endif

        // Randomized traffic with varying write pressure and an asynchronous reset midway.
        doReset();
        for (int phase = 0; phase < 8; phase++) begin
            int wrPct;
            wrPct = (phase % 4 == 0) ? 90 : (phase % 4 == 1) ? 20 : 55;
            for (int c = 0; c < 300; c++) begin
`ifdef UART_TX_FIFO_IRQ_EN
                if ($urandom_range(31) == 0) IrqLevel = 5'($urandom_range(DEPTH));
`endif
                applyStimulus("rnd",
                              $urandom_range(99) < wrPct,
                              8'($urandom),
                              $urandom_range(63) == 0,
                              $urandom_range(15) == 0,
                              $urandom_range(2) != 0,
                              $urandom_range(1) == 1);
            end
            if (phase == 3) begin
                @(negedge CLK);
                TxBusy = 1'b1;
                #2;
                RESETn = 1'b0;
                #1;
                modelReset();
                checkAll("asyncRst");
                @(negedge CLK);
                TxBusy = 1'b0;
                RESETn = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
